key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_pkg.sv | 15 +
 rtl/key_filter.sv | 131 +++++++++++++
 rtl/key_scan.sv | 32 +++
 tb/tb_key_scan.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and default timing for the key scanner
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int DEB_CYC_DEF  = 1_000_000;
    localparam int LONG_CYC_DEF = 50_000_000;

endpackage

// File: rtl/key_filter.sv
// rtl/key_filter.sv - synchronizer, debounce FSM and long-press timer for one key
module key_filter
    import key_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF
) (
    input  logic sys_clk,
    input  logic sys_res,
    input  logic key_n,
    output logic key_value,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    logic              sync_a;
    logic              sync_b;
    logic              ps;
    key_state_t        state;
    key_state_t        state_nx;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              deb_done;
    logic              hold_full;
    logic              long_done;
    logic              press_nx;
    logic              release_nx;
    logic              long_nx;
    logic              value_nx;

    // Flops reset to 1 so a key held through reset is seen as a fresh press
    always_ff @(posedge sys_clk or posedge sys_res) begin
        if (sys_res) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    assign ps        = ~sync_b;
    assign deb_done  = (deb_cnt == DEB_LAST);
    assign hold_full = (hold_cnt == HOLD_LAST);

    always_ff @(posedge sys_clk or posedge sys_res) begin
        if (sys_res) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (ps) state_nx = PRESS_DB;
            end
            PRESS_DB: begin
                if (!ps)          state_nx = IDLE;
                else if (deb_done) state_nx = HELD;
            end
            HELD: begin
                if (!ps) state_nx = RELEASE_DB;
            end
            RELEASE_DB: begin
                if (ps)            state_nx = HELD;
                else if (deb_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A bounce back to HELD never carries a long pulse; it fires a cycle later instead
    always_comb begin
        press_nx   = (state == PRESS_DB) && ps && deb_done;
        release_nx = (state == RELEASE_DB) && !ps && deb_done;
        long_nx    = hold_full && !long_done &&
                     ((state == HELD) || ((state == RELEASE_DB) && !ps));
        value_nx   = (state_nx == HELD) || (state_nx == RELEASE_DB);
    end

    always_ff @(posedge sys_clk or posedge sys_res) begin
        if (sys_res) begin
            deb_cnt <= '0;
        end else if (state_nx != state) begin
            deb_cnt <= '0;
        end else if (((state == PRESS_DB) || (state == RELEASE_DB)) && !deb_done) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Hold time keeps accumulating through release bounce so a long press is not lost
    always_ff @(posedge sys_clk or posedge sys_res) begin
        if (sys_res) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if ((state == PRESS_DB) && (state_nx == HELD)) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if (state_nx == IDLE) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if ((state == HELD) || (state == RELEASE_DB)) begin
            if (!hold_full) hold_cnt <= hold_cnt + 1'b1;
            if (long_nx)    long_done <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_res) begin
        if (sys_res) begin
            key_value   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_value   <= value_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_long    <= long_nx;
        end
    end

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - four independent debounced keys with press/release/long pulses
module key_scan
    import key_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_res,
    input  logic [3:0] key_n,
    output logic [3:0] key_value,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long
);

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_filter #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_filter (
            .sys_clk     (sys_clk),
            .sys_res     (sys_res),
            .key_n       (key_n[k]),
            .key_value   (key_value[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .key_long    (key_long[k])
        );
    end

endmodule

// File: tb/tb_key_scan.sv
// tb/tb_key_scan.sv - scoreboard bench for key_scan with short debounce/long windows
module tb_key_scan;

    localparam int DEB = 8;
    localparam int LNG = 40;
    localparam int LAT = DEB + 2;

    logic       sys_clk = 1'b0;
    logic       sys_res;
    logic [3:0] key_n;
    logic [3:0] key_value;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    key_scan #(
        .DEB_CYC  (DEB),
        .LONG_CYC (LNG)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_res     (sys_res),
        .key_n       (key_n),
        .key_value   (key_value),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // edge_cyc is the first posedge that samples the new key_n level
    function automatic void push(input int edge_cyc, input int delay,
                                 input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        exp_t e;
        e.cyc   = edge_cyc + delay;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        exp_q.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b at cyc=%0d", name, act, want, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_res === 1'b0) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event due cyc=%0d now=%0d press=%b release=%b long=%b",
                         exp_q[0].cyc, cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].lng);
                void'(exp_q.pop_front());
            end
            if ((key_press | key_release | key_long) != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b long=%b",
                             cyc, key_press, key_release, key_long);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.press !== key_press ||
                        mon_e.rel !== key_release || mon_e.lng !== key_long) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d press=%b release=%b long=%b want cyc=%0d press=%b release=%b long=%b",
                                 cyc, key_press, key_release, key_long,
                                 mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lng);
                    end
                end
            end
        end
    end

    initial begin
        key_n   = 4'hF;
        sys_res = 1'b1;
        step(3);
        chk("reset_value", key_value, 4'b0000);
        chk("reset_press", key_press, 4'b0000);
        chk("reset_release", key_release, 4'b0000);
        chk("reset_long", key_long, 4'b0000);
        sys_res = 1'b0;
        step(5);
        chk("idle_value", key_value, 4'b0000);

        // single press and release on key 0
        key_n[0] = 1'b0;
        push(cyc + 1, LAT, 4'b0001, 4'b0000, 4'b0000);
        step(20);
        chk("k0_value_held", key_value, 4'b0001);
        key_n[0] = 1'b1;
        push(cyc + 1, LAT, 4'b0000, 4'b0001, 4'b0000);
        step(20);
        chk("k0_value_released", key_value, 4'b0000);

        // bounce shorter than the debounce window never qualifies
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0;
            step(3);
            key_n[1] = 1'b1;
            step(3);
        end
        step(20);
        chk("k1_bounce_value", key_value, 4'b0000);

        // long hold on key 2
        key_n[2] = 1'b0;
        push(cyc + 1, LAT, 4'b0100, 4'b0000, 4'b0000);
        push(cyc + 1, LAT + LNG, 4'b0000, 4'b0000, 4'b0100);
        step(60);
        chk("k2_value_held", key_value, 4'b0100);
        key_n[2] = 1'b1;
        push(cyc + 1, LAT, 4'b0000, 4'b0100, 4'b0000);
        step(20);
        chk("k2_value_released", key_value, 4'b0000);

        // all keys together
        key_n = 4'h0;
        push(cyc + 1, LAT, 4'b1111, 4'b0000, 4'b0000);
        step(15);
        chk("all_value_held", key_value, 4'b1111);
        key_n = 4'hF;
        push(cyc + 1, LAT, 4'b0000, 4'b1111, 4'b0000);
        step(20);
        chk("all_value_released", key_value, 4'b0000);

        // reset in the middle of a hold restarts the press
        key_n[0] = 1'b0;
        push(cyc + 1, LAT, 4'b0001, 4'b0000, 4'b0000);
        step(15);
        chk("k0_pre_reset_value", key_value, 4'b0001);
        sys_res = 1'b1;
        #1;
        chk("midreset_value", key_value, 4'b0000);
        chk("midreset_pulses", key_press | key_release | key_long, 4'b0000);
        step(3);
        chk("midreset_value_late", key_value, 4'b0000);
        sys_res = 1'b0;
        push(cyc + 1, LAT, 4'b0001, 4'b0000, 4'b0000);
        step(15);
        chk("k0_post_reset_value", key_value, 4'b0001);
        key_n[0] = 1'b1;
        push(cyc + 1, LAT, 4'b0000, 4'b0001, 4'b0000);
        step(20);
        chk("k0_final_value", key_value, 4'b0000);

        step(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
